polyline_buffer_seq: RTL and testbench

- Sequencer that feeds the Basic Buffer op one polyline segment at a time.
- Accepts a stream of 4-bit vertices over a valid/ready handshake and stores them in a local point memory.
- Issues consecutive vertex pairs as (A,B,C,D) to the external combinational buffer op, captures (M,N), and emits one result per segment on an output valid/ready stream.
- Sits between the tinyspu input deserializer and the output serializer.

---
 rtl/polyline_buffer_seq.sv | 159 +++++++++++++++
 tb/tb_polyline_buffer_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/polyline_buffer_seq.sv
// rtl/polyline_buffer_seq.sv - stores a polyline and feeds its segments to the buffer op, one result per segment
// Optional closing segment (p[count-1] -> p[0]) when POLYBUF_CLOSE_RING_EN is defined.
module polyline_buffer_seq #(
    parameter int MAX_PTS = 8,
    parameter int PTR_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_x,
    input  logic [3:0] in_y,
    input  logic       in_last,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic [3:0] op_c,
    output logic [3:0] op_d,
    input  logic [3:0] op_m,
    input  logic [3:0] op_n,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_x,
    output logic [3:0] out_y,
    output logic       out_last,
    output logic       busy,
    output logic       err_overflow
);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, EMIT} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] seg_q;
    logic [7:0]       start_q;
    logic [7:0]       end_q;
    logic [7:0]       pts_q [MAX_PTS];
    logic [3:0]       out_x_q;
    logic [3:0]       out_y_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             err_q;

    logic             in_fire;
    logic [7:0]       in_pt;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] seg_d;
    logic [CNT_W-1:0] nseg;
    logic [PTR_W-1:0] start_idx;
    logic [PTR_W-1:0] end_idx;
    logic             load_done;

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign in_fire   = in_valid && in_ready;
    assign in_pt     = {in_x, in_y};
    assign count_d   = count_q + CNT_W'(1);
    assign seg_d     = seg_q + CNT_W'(1);
    assign load_done = in_last || (count_d == CNT_W'(MAX_PTS));
    assign start_idx = seg_d[PTR_W-1:0];

    always_comb begin
        nseg    = (count_q >= CNT_W'(2)) ? (count_q - CNT_W'(1)) : CNT_W'(1);
        end_idx = start_idx + PTR_W'(1);
`ifdef POLYBUF_CLOSE_RING_EN
        if (count_q >= CNT_W'(3)) begin
            nseg = count_q;
        end
        // the closing segment ends back at the first vertex
        if (seg_d == count_q - CNT_W'(1)) begin
            end_idx = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            pts_q[count_q[PTR_W-1:0]] <= in_pt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            seg_q       <= '0;
            start_q     <= '0;
            end_q       <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        count_q <= CNT_W'(1);
                        err_q   <= 1'b0;
                        if (in_last) begin
                            // single-point polyline: both ends are the same vertex
                            start_q <= in_pt;
                            end_q   <= in_pt;
                            state_q <= ISSUE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        count_q <= count_d;
                        if (load_done) begin
                            // second vertex may still be on the input bus this cycle
                            start_q <= pts_q[0];
                            end_q   <= (count_q == CNT_W'(1)) ? in_pt : pts_q[PTR_W'(1)];
                            state_q <= ISSUE;
                            if (!in_last) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    out_x_q     <= op_m;
                    out_y_q     <= op_n;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (seg_q == nseg - CNT_W'(1));
                    state_q     <= EMIT;
                end
                default: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            seg_q   <= '0;
                            count_q <= '0;
                            state_q <= IDLE;
                        end else begin
                            seg_q   <= seg_d;
                            start_q <= pts_q[start_idx];
                            end_q   <= pts_q[end_idx];
                            state_q <= ISSUE;
                        end
                    end
                end
            endcase
        end
    end

    assign op_a         = start_q[7:4];
    assign op_b         = start_q[3:0];
    assign op_c         = end_q[7:4];
    assign op_d         = end_q[3:0];
    assign out_x        = out_x_q;
    assign out_y        = out_y_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign err_overflow = err_q;
endmodule

// File: tb/tb_polyline_buffer_seq.sv
// tb/tb_polyline_buffer_seq.sv - randomized bench for polyline_buffer_seq with a queue-based segment model
module tb_polyline_buffer_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_x = '0;
    logic [3:0] in_y = '0;
    logic       in_ready, out_valid, out_last, busy, err_overflow;
    logic [3:0] op_a, op_b, op_c, op_d, op_m, op_n, out_x, out_y;

    int          nvec = 0;
    int          nerr = 0;
    int          or_mode = 1;
    int unsigned cyc = 0;
    int unsigned last_cyc = 0;
    bit          chain = 1'b0;
    bit          prev_stall = 1'b0;
    logic [25:0] snap, saved;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       last;
    } exp_t;

    exp_t       expq[$];
    exp_t       e;
    logic [3:0] px[16];
    logic [3:0] py[16];

    polyline_buffer_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_last(in_last),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d), .op_m(op_m), .op_n(op_n),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_last(out_last),
        .busy(busy), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // stand-in for the external combinational buffer op
    function automatic logic [7:0] bop(input logic [3:0] a, b, c, d);
        if (a == c && b == d)     return {a + 4'd2, b + 4'd2};
        else if (b == d)          return {a - 4'd2, b - 4'd2};
        else if (a == c && d > b) return {a + 4'd2, b - 4'd2};
        else if (a == c)          return {a + 4'd2, d + 4'd4};
        else                      return {a, b};
    endfunction

    assign {op_m, op_n} = bop(op_a, op_b, op_c, op_d);

    function automatic bit ring(input int n);
`ifdef POLYBUF_CLOSE_RING_EN
        return n >= 3;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] x, input logic [3:0] y, input logic last);
        expq.push_back(exp_t'({x, y, last}));
    endtask

    task automatic model_push(input int n);
        logic [7:0] r;
        if (n == 1) begin
            r = bop(px[0], py[0], px[0], py[0]);
            push_exp(r[7:4], r[3:0], 1'b1);
        end else begin
            for (int i = 0; i < n - 1; i++) begin
                r = bop(px[i], py[i], px[i+1], py[i+1]);
                push_exp(r[7:4], r[3:0], ring(n) ? 1'b0 : (i == n - 2));
            end
            if (ring(n)) begin
                r = bop(px[n-1], py[n-1], px[0], py[0]);
                push_exp(r[7:4], r[3:0], 1'b1);
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (or_mode)
            0:       out_ready = ($urandom_range(0, 9) < 7);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            chain      = 1'b0;
        end else begin
            snap = {out_valid, out_x, out_y, out_last, op_a, op_b, op_c, op_d};
            if (prev_stall) chk("hold_stable", 32'(snap), 32'(saved));
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("out_x", out_x, e.x);
                    chk("out_y", out_y, e.y);
                    chk("out_last", out_last, e.last);
                end
                if (chain) chk("throughput_gap", cyc - last_cyc, 2);
                chain    = (or_mode == 1) && !out_last;
                last_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            saved      = snap;
        end
    end

    task automatic send_pt(input logic [3:0] x, input logic [3:0] y, input logic last);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_last = last;
        for (int t = 0; t < 64 && !ok; t++) begin
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("in_handshake", ok, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (expq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", expq.size(), 0);
        @(negedge clk);
        chk("busy_idle", busy, 0);
    endtask

    task automatic run_poly(input int n, input bit ovf, input bit drain);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send_pt(px[i], py[i], (i == n - 1) && !ovf);
            if (i == 0) chk("err_cleared", err_overflow, 0);
        end
        chk("in_ready_after_last", in_ready, 0);
        chk("err_overflow", err_overflow, ovf);
        chk("latency_k1", out_valid, 0);
        @(negedge clk);
        chk("latency_k2", out_valid, 1);
        if (drain) wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit ovf;
        or_mode = 1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_flags", {in_ready, out_valid, busy, err_overflow, out_last}, 5'b10000);
        chk("reset_ops", {op_a, op_b, op_c, op_d}, 0);
        chk("reset_out", {out_x, out_y}, 0);
        rst = 1'b0;

        px[0] = 4'd1; py[0] = 4'd5; px[1] = 4'd4; py[1] = 4'd5;
        push_exp(4'd15, 4'd3, 1'b1);
        run_poly(2, 1'b0, 1'b1);

        px[0] = 4'd6; py[0] = 4'd2; px[1] = 4'd6; py[1] = 4'd9;
        push_exp(4'd8, 4'd0, 1'b1);
        run_poly(2, 1'b0, 1'b1);

        px[0] = 4'd3; py[0] = 4'd3; px[1] = 4'd7; py[1] = 4'd9; px[2] = 4'd7; py[2] = 4'd1;
        push_exp(4'd3, 4'd3, 1'b0);
`ifdef POLYBUF_CLOSE_RING_EN
        push_exp(4'd9, 4'd5, 1'b0);
        push_exp(4'd7, 4'd1, 1'b1);
`else
        push_exp(4'd9, 4'd5, 1'b1);
`endif
        run_poly(3, 1'b0, 1'b1);

        px[0] = 4'd5; py[0] = 4'd5;
        push_exp(4'd7, 4'd7, 1'b1);
        run_poly(1, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            px[i] = 4'($urandom);
            py[i] = 4'($urandom);
        end
        model_push(8);
        run_poly(8, 1'b1, 1'b1);

        or_mode = 2;
        px[0] = 4'd3; py[0] = 4'd3; px[1] = 4'd7; py[1] = 4'd9; px[2] = 4'd7; py[2] = 4'd1;
        run_poly(3, 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
        end
        chk("stall_out", {out_x, out_y, out_last}, {4'd3, 4'd3, 1'b0});
        chk("stall_ops", {op_a, op_b, op_c, op_d}, {4'd3, 4'd3, 4'd7, 4'd9});
        rst = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        expq.delete();

        or_mode = 0;
        repeat (60) begin
            n = $urandom_range(1, 8);
            ovf = (n == 8) && ($urandom_range(0, 2) == 0);
            for (int i = 0; i < n; i++) begin
                px[i] = 4'($urandom);
                py[i] = 4'($urandom);
            end
            model_push(n);
            run_poly(n, ovf, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
